mul_wb_merge: RTL and testbench
===============================

Name: mul_wb_merge

Overview:
- Receiving end of the multiply pipeline's result interface: regwrite, wreg, result, overflow.
- Buffers multiply results and merges them with the single-cycle ALU writeback path onto the one register-file write port.
- ALU writeback has priority. Multiply results queue in a small FIFO and drain on free cycles.
- Provides issue back-pressure (mul_stall) and write-after-write protection against stale multiply results.

Parameters:
- DATA_W, 32, register width (matches REG_SIZE)
- ADDR_W, 5, register address width (matches REG_ADDR)
- DEPTH, 4, multiply result FIFO entries (power of two, ≥2)
- STALL_LVL, 2, FIFO occupancy at or above which mul_stall asserts

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mul_regwrite_in  in  1  multiply result valid, write requested
- mul_wreg_in  in  ADDR_W  multiply destination register
- mul_result_in  in  DATA_W  multiply low-word result
- mul_overflow_in  in  1  multiply overflow flag
- alu_regwrite_in  in  1  ALU writeback valid
- alu_wreg_in  in  ADDR_W  ALU destination register
- alu_result_in  in  DATA_W  ALU result
- wb_we  out  1  register-file write enable (registered)
- wb_addr  out  ADDR_W  register-file write address (registered)
- wb_data  out  DATA_W  register-file write data (registered)
- wb_src  out  1  0 = ALU, 1 = multiply (registered)
- mul_ovf_out  out  1  one-cycle pulse with a committed multiply write whose overflow flag was set
- mul_stall  out  1  combinational from occupancy register; stop issuing multiplies
- fifo_err  out  1  sticky; a push was attempted while full

Behaviour:
Reset
- Async on rst_n low: all outputs 0, count = 0, all entry valid bits cleared, fifo_err = 0.
- Reset mid-operation discards all queued entries.

Push, drop and kill
- Push occurs when mul_regwrite_in = 1 and mul_wreg_in != 0. Writes to r0 are dropped in both paths; an ALU write to r0 gives wb_we = 0.
- Entry contents: {valid, wreg, result, overflow}.
- WAW kill: when alu_regwrite_in = 1 and alu_wreg_in != 0, clear valid on every FIFO entry with wreg == alu_wreg_in.
- The kill also applies to a multiply input arriving in the same cycle. That input is pushed with valid = 0, because in-order issue makes it older.

Per-cycle priority (decided at the edge, outputs registered, latency 1)
1. alu_regwrite_in = 1: output the ALU write with wb_src = 0. The FIFO does not pop.
2. Otherwise, FIFO non-empty: pop the head.
   - Head valid: wb_we = 1, wb_src = 1, data and address from the head; mul_ovf_out = head overflow.
   - Head killed: wb_we = 0, and the slot is still consumed.
3. Otherwise, FIFO empty and a multiply input is present: bypass straight to the output with no push (latency 1). The bypass obeys the kill and r0 rules.
4. Otherwise: wb_we = 0, mul_ovf_out = 0.

Occupancy and error rules
- Simultaneous push and pop: count unchanged, and the order is preserved (the pop takes the head, the push goes to the tail).
- Full (count == DEPTH) with a push and no pop in the same cycle: the entry is dropped and fifo_err sets. fifo_err clears only on reset.
- mul_stall = (count >= STALL_LVL).
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- wb_addr, wb_data and wb_src hold their last values when wb_we = 0.

Test Plan:
1. Reset, then mul r5 = 0x00000006 with ALU idle → next cycle wb_we = 1, wb_addr = 5, wb_data = 6, wb_src = 1; FIFO stays empty.
2. ALU writes r3 for 3 consecutive cycles while muls to r7, r8, r9 arrive → ALU writes r3 on those 3 cycles, then r7, r8, r9 commit in order; mul_stall high while count ≥ 2.
3. Queue mul r4 while the ALU is busy, then ALU writes r4 → ALU r4 commits; the later pop of the r4 entry gives wb_we = 0. Repeat with the mul r4 arriving in the same cycle as the ALU write → same result.
4. Mul r6 with mul_overflow_in = 1, result 0x80000000 → mul_ovf_out pulses exactly in the commit cycle, wb_data = 0x80000000.
5. Hold ALU busy and push 5 muls (DEPTH = 4) → fifo_err = 1 after the 5th; the first 4 commit after the ALU goes idle and the 5th never does. Then mul and ALU writes to r0 → wb_we = 0 throughout.
6. Deassert rst_n with 3 entries queued → all outputs 0 immediately, count 0, no further commits.

Source files
------------

// File: rtl/mul_wb_merge.sv
// Merges buffered multiply results with the single-cycle ALU writeback onto one
// register-file write port. The ALU has priority, and ALU writes cancel stale queued multiply results.
module mul_wb_merge #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 4,
    parameter int STALL_LVL = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mul_regwrite_in,
    input  logic [ADDR_W-1:0] mul_wreg_in,
    input  logic [DATA_W-1:0] mul_result_in,
    input  logic              mul_overflow_in,
    input  logic              alu_regwrite_in,
    input  logic [ADDR_W-1:0] alu_wreg_in,
    input  logic [DATA_W-1:0] alu_result_in,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_src,
    output logic              mul_ovf_out,
    output logic              mul_stall,
    output logic              fifo_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Handshake: mul_regwrite_in is a valid strobe with no ready. The issuing stage must
    // stop sending while mul_stall is high. A push into a full FIFO that is not draining
    // in the same cycle is lost, and fifo_err records that loss until reset.

    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;
    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_ovf;
    logic [ADDR_W-1:0] ent_wreg   [DEPTH];
    logic [DATA_W-1:0] ent_result [DEPTH];

    logic alu_kill, mul_req, fifo_empty, fifo_full;
    logic pop, bypass, push, overrun, push_valid;

    always_comb begin
        alu_kill   = alu_regwrite_in && (alu_wreg_in != '0);
        mul_req    = mul_regwrite_in && (mul_wreg_in != '0);
        fifo_empty = (count == '0);
        fifo_full  = (count == CNT_W'(DEPTH));
        pop        = !alu_regwrite_in && !fifo_empty;
        bypass     = !alu_regwrite_in && fifo_empty && mul_req;
        push       = mul_req && !bypass && (!fifo_full || pop);
        overrun    = mul_req && !bypass && fifo_full && !pop;
        // An in-flight multiply is older than a same-cycle ALU write to the same register.
        push_valid = !(alu_kill && (mul_wreg_in == alu_wreg_in));
    end

    assign mul_stall = (count >= CNT_W'(STALL_LVL));

    always_ff @(posedge clk) begin
        if (push) begin
            ent_wreg[tail]   <= mul_wreg_in;
            ent_result[tail] <= mul_result_in;
            ent_ovf[tail]    <= mul_overflow_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            ent_valid   <= '0;
            wb_we       <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            wb_src      <= 1'b0;
            mul_ovf_out <= 1'b0;
            fifo_err    <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_kill && (ent_wreg[i] == alu_wreg_in))
                    ent_valid[i] <= 1'b0;
            end
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PTR_W'(1);
            end
            // The push is written last so that, when the FIFO is full and popping, it wins on the shared slot.
            if (push) begin
                ent_valid[tail] <= push_valid;
                tail            <= tail + PTR_W'(1);
            end
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);

            fifo_err    <= fifo_err | overrun;
            wb_we       <= 1'b0;
            mul_ovf_out <= 1'b0;
            if (alu_regwrite_in) begin
                if (alu_kill) begin
                    wb_we   <= 1'b1;
                    wb_addr <= alu_wreg_in;
                    wb_data <= alu_result_in;
                    wb_src  <= 1'b0;
                end
            end else if (pop) begin
                if (ent_valid[head]) begin
                    wb_we       <= 1'b1;
                    wb_addr     <= ent_wreg[head];
                    wb_data     <= ent_result[head];
                    wb_src      <= 1'b1;
                    mul_ovf_out <= ent_ovf[head];
                end
            end else if (bypass) begin
                wb_we       <= 1'b1;
                wb_addr     <= mul_wreg_in;
                wb_data     <= mul_result_in;
                wb_src      <= 1'b1;
                mul_ovf_out <= mul_overflow_in;
            end
        end
    end

endmodule

// File: tb/tb_mul_wb_merge.sv
// Self-checking bench for mul_wb_merge. It pairs directed scenarios with random traffic and
// compares them against a queue-based reference model.
module tb_mul_wb_merge;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
    localparam int DEPTH     = 4;
    localparam int STALL_LVL = 2;
    localparam int VEC_W     = 1 + ADDR_W + DATA_W + 4;

    logic              clk, rst_n;
    logic              mul_regwrite_in, mul_overflow_in, alu_regwrite_in;
    logic [ADDR_W-1:0] mul_wreg_in, alu_wreg_in;
    logic [DATA_W-1:0] mul_result_in, alu_result_in;
    logic              wb_we, wb_src, mul_ovf_out, mul_stall, fifo_err;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    int n_tests = 0;
    int n_fail  = 0;

    mul_wb_merge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STALL_LVL(STALL_LVL)) dut (
        .clk(clk), .rst_n(rst_n),
        .mul_regwrite_in(mul_regwrite_in), .mul_wreg_in(mul_wreg_in),
        .mul_result_in(mul_result_in), .mul_overflow_in(mul_overflow_in),
        .alu_regwrite_in(alu_regwrite_in), .alu_wreg_in(alu_wreg_in),
        .alu_result_in(alu_result_in),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_src(wb_src),
        .mul_ovf_out(mul_ovf_out), .mul_stall(mul_stall), .fifo_err(fifo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              v;
        logic [ADDR_W-1:0] w;
        logic [DATA_W-1:0] d;
        logic              o;
    } ent_t;

    ent_t              mq[$];
    logic              exp_we, exp_src, exp_ovf, exp_err;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic [ADDR_W-1:0] exp_q[$];

    logic [VEC_W-1:0] dut_vec;
    assign dut_vec = {wb_we, wb_addr, wb_data, wb_src, mul_ovf_out, mul_stall, fifo_err};

    function automatic logic [VEC_W-1:0] exp_vec();
        logic stall;
        stall = (mq.size() >= STALL_LVL);
        return {exp_we, exp_addr, exp_data, exp_src, exp_ovf, stall, exp_err};
    endfunction

    function automatic void model_reset();
        mq.delete();
        exp_we = 0; exp_addr = '0; exp_data = '0; exp_src = 0; exp_ovf = 0; exp_err = 0;
    endfunction

    // Advances the model by one clock edge, using the inputs currently applied.
    function automatic void model_step();
        ent_t h;
        ent_t n;
        logic ak, mp, bypassed;
        ak = alu_regwrite_in && alu_wreg_in != 0;
        mp = mul_regwrite_in && mul_wreg_in != 0;
        bypassed = 0;
        exp_we = 0;
        exp_ovf = 0;
        if (ak) foreach (mq[i]) if (mq[i].w == alu_wreg_in) mq[i].v = 0;
        if (alu_regwrite_in) begin
            if (ak) begin
                exp_we = 1; exp_addr = alu_wreg_in; exp_data = alu_result_in; exp_src = 0;
            end
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            if (h.v) begin
                exp_we = 1; exp_addr = h.w; exp_data = h.d; exp_src = 1; exp_ovf = h.o;
            end
        end else if (mp) begin
            bypassed = 1;
            exp_we = 1; exp_addr = mul_wreg_in; exp_data = mul_result_in; exp_src = 1;
            exp_ovf = mul_overflow_in;
        end
        if (mp && !bypassed) begin
            if (mq.size() < DEPTH) begin
                n.v = !(ak && mul_wreg_in == alu_wreg_in);
                n.w = mul_wreg_in; n.d = mul_result_in; n.o = mul_overflow_in;
                mq.push_back(n);
            end else begin
                exp_err = 1;
            end
        end
    endfunction

    task automatic drive(input logic mrw, input logic [ADDR_W-1:0] mw, input logic [DATA_W-1:0] md,
                         input logic mo, input logic arw, input logic [ADDR_W-1:0] aw,
                         input logic [DATA_W-1:0] ad);
        mul_regwrite_in = mrw; mul_wreg_in = mw; mul_result_in = md; mul_overflow_in = mo;
        alu_regwrite_in = arw; alu_wreg_in = aw; alu_result_in = ad;
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic test_reset();
        rst_n = 0;
        mul_regwrite_in = 0; mul_wreg_in = '0; mul_result_in = '0; mul_overflow_in = 0;
        alu_regwrite_in = 0; alu_wreg_in = '0; alu_result_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if (dut_vec !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h exp %h", dut_vec, {VEC_W{1'b0}});
        end
        rst_n = 1;
        idle();
        n_tests++;
        if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL reset_idle: got %h exp %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_bypass();
        drive(1, 5'd5, 32'h6, 0, 0, '0, '0);
        n_tests++;
        if ({wb_we, wb_addr, wb_data, wb_src, mul_stall} !== {1'b1, 5'd5, 32'h6, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL bypass: got %h exp %h",
                {wb_we, wb_addr, wb_data, wb_src, mul_stall}, {1'b1, 5'd5, 32'h6, 1'b1, 1'b0});
        end
        idle();
        n_tests++;
        if ((wb_we !== 1'b0) || (dut_vec !== exp_vec())) begin
            n_fail++; $display("FAIL bypass_empty: got %h exp %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_alu_priority();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(5'd3);
            drive(1, ADDR_W'(7 + i), $urandom, 0, 1, 5'd3, $urandom);
            n_tests++;
            if ((mul_stall !== (i >= 1)) || (dut_vec !== exp_vec()) || (wb_addr !== exp_q[0])) begin
                n_fail++; $display("FAIL alu_priority_%0d: got %h exp %h", i, dut_vec, exp_vec());
            end
            void'(exp_q.pop_front());
        end
        for (int i = 0; i < 3; i++) exp_q.push_back(ADDR_W'(7 + i));
        for (int i = 0; i < 3; i++) begin
            idle();
            n_tests++;
            if ((wb_we !== 1'b1) || (wb_src !== 1'b1) || (wb_addr !== exp_q[0]) || (dut_vec !== exp_vec())) begin
                n_fail++; $display("FAIL drain_order_%0d: got %h exp %h (addr %0d want %0d)",
                    i, dut_vec, exp_vec(), wb_addr, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_waw_kill();
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                drive(1, 5'd4, 32'h44, 0, 1, 5'd1, 32'h11);
                drive(0, '0, '0, 0, 1, 5'd4, 32'hA4);
            end else begin
                drive(1, 5'd4, 32'h44, 0, 1, 5'd4, 32'hA4);
            end
            n_tests++;
            if ({wb_we, wb_addr, wb_data, wb_src} !== {1'b1, 5'd4, 32'hA4, 1'b0}) begin
                n_fail++; $display("FAIL waw_alu_%0d: got %h exp %h", pass,
                    {wb_we, wb_addr, wb_data, wb_src}, {1'b1, 5'd4, 32'hA4, 1'b0});
            end
            idle();
            n_tests++;
            if ((wb_we !== 1'b0) || (wb_data !== 32'hA4) || (dut_vec !== exp_vec())) begin
                n_fail++; $display("FAIL waw_killed_pop_%0d: got %h exp %h", pass, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_overflow();
        drive(1, 5'd6, 32'h8000_0000, 1, 0, '0, '0);
        n_tests++;
        if ({mul_ovf_out, wb_we, wb_data} !== {1'b1, 1'b1, 32'h8000_0000}) begin
            n_fail++; $display("FAIL ovf_bypass: got %h exp %h", {mul_ovf_out, wb_we, wb_data},
                {1'b1, 1'b1, 32'h8000_0000});
        end
        drive(1, 5'd6, 32'h8000_0000, 1, 1, 5'd2, 32'h22);
        n_tests++;
        if (mul_ovf_out !== 1'b0) begin
            n_fail++; $display("FAIL ovf_queued_early: got %b exp 0", mul_ovf_out);
        end
        idle();
        n_tests++;
        if ({mul_ovf_out, wb_we, wb_addr, wb_data} !== {1'b1, 1'b1, 5'd6, 32'h8000_0000}) begin
            n_fail++; $display("FAIL ovf_commit: got %h exp %h", {mul_ovf_out, wb_we, wb_addr, wb_data},
                {1'b1, 1'b1, 5'd6, 32'h8000_0000});
        end
        idle();
        n_tests++;
        if (mul_ovf_out !== 1'b0) begin
            n_fail++; $display("FAIL ovf_pulse_len: got %b exp 0", mul_ovf_out);
        end
    endtask

    task automatic test_fifo_err();
        for (int i = 0; i < 5; i++) begin
            drive(1, ADDR_W'(10 + i), 32'(100 + i), 0, 1, 5'd2, 32'h22);
            n_tests++;
            if ((fifo_err !== (i == 4)) || (dut_vec !== exp_vec())) begin
                n_fail++; $display("FAIL fill_%0d: got %h exp %h", i, dut_vec, exp_vec());
            end
        end
        for (int i = 0; i < 5; i++) begin
            idle();
            n_tests++;
            if ((wb_we !== (i < 4)) || (i < 4 && wb_addr !== ADDR_W'(10 + i)) || (fifo_err !== 1'b1)
                || (dut_vec !== exp_vec())) begin
                n_fail++; $display("FAIL overflow_drain_%0d: got %h exp %h", i, dut_vec, exp_vec());
            end
        end
        drive(1, 5'd0, 32'h55, 0, 0, '0, '0);
        drive(0, '0, '0, 0, 1, 5'd0, 32'h66);
        drive(1, 5'd0, 32'h77, 0, 1, 5'd0, 32'h88);
        n_tests++;
        if ((wb_we !== 1'b0) || (dut_vec !== exp_vec())) begin
            n_fail++; $display("FAIL r0_write: got %h exp %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) drive(1, ADDR_W'(20 + i), $urandom, 0, 1, 5'd1, $urandom);
        mul_regwrite_in = 0; alu_regwrite_in = 0;
        #2 rst_n = 0;
        #1;
        model_reset();
        n_tests++;
        if (dut_vec !== '0) begin
            n_fail++; $display("FAIL reset_mid: got %h exp %h", dut_vec, {VEC_W{1'b0}});
        end
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            idle();
            n_tests++;
            if ((wb_we !== 1'b0) || (dut_vec !== exp_vec())) begin
                n_fail++; $display("FAIL reset_mid_no_commit_%0d: got %h exp %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1), ADDR_W'($urandom_range(0, 7)), $urandom, $urandom_range(0, 1),
                  $urandom_range(0, 99) < 45, ADDR_W'($urandom_range(0, 7)), $urandom);
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL random_%0d: got %h exp %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_alu_priority();
        test_waw_kill();
        test_overflow();
        test_fifo_err();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
